// File: rtl/vrf_pkg.sv
`default_nettype none
// ============================================================================
// Module : vrf_pkg
// Brief  : Geometry constants, types and beat helpers shared by the VRF
//          access sequencer and its beat generators.
// Rev    : 1.0 - initial release
// ============================================================================
package vrf_pkg;

    localparam int NumWords   = 1024;
    localparam int NumBanks   = 4;
    localparam int NumVRs     = 32;
    localparam int DataWidth  = 32;
    localparam int ElemsPerVR = NumWords / NumVRs;
    localparam int BeatsPerVR = ElemsPerVR / NumBanks;
    localparam int AddrWidth  = $clog2(NumWords / NumBanks);
    localparam int VregW      = $clog2(NumVRs);
    localparam int VlW        = $clog2(ElemsPerVR + 1);
    // Wide enough to hold a full beat count, not just a beat index.
    localparam int BeatW      = $clog2(BeatsPerVR + 1);

    typedef logic [VregW-1:0]     vreg_t;
    typedef logic [VlW-1:0]       vl_t;
    typedef logic [BeatW-1:0]     beat_t;
    typedef logic [AddrWidth-1:0] bank_addr_t;
    typedef logic [NumBanks-1:0]  bank_mask_t;

    typedef enum logic [0:0] {
        R_IDLE  = 1'b0,
        R_ISSUE = 1'b1
    } rd_state_e;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_DATA = 1'b1
    } wr_state_e;

    function automatic vl_t clamp_vl(input vl_t vl);
        return (int'(vl) > ElemsPerVR) ? vl_t'(ElemsPerVR) : vl;
    endfunction

    function automatic beat_t beat_count(input vl_t vl);
        return beat_t'((int'(vl) + NumBanks - 1) / NumBanks);
    endfunction

    function automatic bank_mask_t beat_mask(input vl_t vl, input beat_t beat);
        bank_mask_t m;
        m = '0;
        for (int i = 0; i < NumBanks; i++) begin
            m[i] = ((int'(beat) * NumBanks + i) < int'(vl));
        end
        return m;
    endfunction

endpackage : vrf_pkg
`default_nettype wire

// File: rtl/vrf_beat_gen.sv
`default_nettype none
// ============================================================================
// Module : vrf_beat_gen
// Brief  : Per-channel beat counter with bank address, tail mask and last flag.
// Rev    : 1.0 - initial release
// ============================================================================
module vrf_beat_gen
    import vrf_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [VregW-1:0]     vreg_i,
    input  logic [VlW-1:0]       vl_i,
    input  logic                 step_i,
    output logic [VregW-1:0]     vreg_o,
    output logic [AddrWidth-1:0] addr_o,
    output logic [NumBanks-1:0]  mask_o,
    output logic                 last_o
);

    vreg_t vreg_q, vreg_d;
    vl_t   vl_q,   vl_d;
    beat_t beat_q, beat_d;

    // vl_i arrives already clamped; a new command always restarts at beat 0.
    always_comb begin
        vreg_d = vreg_q;
        vl_d   = vl_q;
        beat_d = beat_q;
        if (load_i) begin
            vreg_d = vreg_i;
            vl_d   = vl_i;
            beat_d = '0;
        end else if (step_i) begin
            beat_d = beat_q + beat_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vreg_q <= '0;
            vl_q   <= '0;
            beat_q <= '0;
        end else begin
            vreg_q <= vreg_d;
            vl_q   <= vl_d;
            beat_q <= beat_d;
        end
    end

    assign vreg_o = vreg_q;
    assign addr_o = bank_addr_t'(vreg_q) * bank_addr_t'(BeatsPerVR) + bank_addr_t'(beat_q);
    assign mask_o = beat_mask(vl_q, beat_q);
    assign last_o = (beat_q == (beat_count(vl_q) - beat_t'(1)));

endmodule : vrf_beat_gen
`default_nettype wire

// File: rtl/vrf_access_seq.sv
`default_nettype none
// ============================================================================
// Module : vrf_access_seq
// Brief  : Turns whole-vector-register read/write commands into per-beat,
//          per-bank SRAM accesses with tail masking and same-register blocking.
// Rev    : 1.0 - initial release
// ============================================================================
module vrf_access_seq
    import vrf_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rd_cmd_valid_i,
    output logic                           rd_cmd_ready_o,
    input  logic [VregW-1:0]               rd_cmd_vreg_i,
    input  logic [VlW-1:0]                 rd_cmd_vl_i,
    output logic                           rd_data_valid_o,
    output logic [NumBanks*DataWidth-1:0]  rd_data_o,
    output logic [NumBanks-1:0]            rd_data_mask_o,
    output logic                           rd_data_last_o,
    input  logic                           wr_cmd_valid_i,
    output logic                           wr_cmd_ready_o,
    input  logic [VregW-1:0]               wr_cmd_vreg_i,
    input  logic [VlW-1:0]                 wr_cmd_vl_i,
    input  logic                           wr_data_valid_i,
    output logic                           wr_data_ready_o,
    input  logic [NumBanks*DataWidth-1:0]  wr_data_i,
    output logic                           wr_done_o,
    output logic [NumBanks-1:0]            sram_re_o,
    output logic [NumBanks-1:0]            sram_we_o,
    output logic [NumBanks*AddrWidth-1:0]  sram_r_addr_o,
    output logic [NumBanks*AddrWidth-1:0]  sram_w_addr_o,
    output logic [NumBanks*DataWidth-1:0]  sram_wdata_o,
    input  logic [NumBanks*DataWidth-1:0]  sram_rdata_i
);

    rd_state_e  rd_state_q, rd_state_d;
    wr_state_e  wr_state_q, wr_state_d;

    logic       rd_valid_q, rd_valid_d;
    bank_mask_t rd_mask_q,  rd_mask_d;
    logic       rd_last_q,  rd_last_d;
    logic       wr_done_q,  wr_done_d;

    vreg_t      rd_vreg, wr_vreg;
    bank_addr_t rd_addr, wr_addr;
    bank_mask_t rd_mask, wr_mask;
    logic       rd_last, wr_last;

    vl_t        rd_vl_c, wr_vl_c;
    logic       rd_fire, wr_fire;
    logic       rd_issue, wr_active, wr_beat;

    assign rd_vl_c   = clamp_vl(rd_cmd_vl_i);
    assign wr_vl_c   = clamp_vl(wr_cmd_vl_i);
    assign rd_issue  = (rd_state_q == R_ISSUE);
    assign wr_active = (wr_state_q == W_DATA);
    assign wr_beat   = wr_active && wr_data_valid_i;

    // On a same-register tie the read is granted and the write waits.
    assign rd_cmd_ready_o = (rd_state_q == R_IDLE) &&
                            !(wr_active && (wr_vreg == rd_cmd_vreg_i));
    assign rd_fire        = rd_cmd_valid_i && rd_cmd_ready_o;
    assign wr_cmd_ready_o = (wr_state_q == W_IDLE) &&
                            !(rd_issue && (rd_vreg == wr_cmd_vreg_i)) &&
                            !(rd_fire && (rd_cmd_vreg_i == wr_cmd_vreg_i));
    assign wr_fire        = wr_cmd_valid_i && wr_cmd_ready_o;

    vrf_beat_gen u_rd_gen (
        .clk    (clk),
        .rst    (rst),
        .load_i (rd_fire),
        .vreg_i (rd_cmd_vreg_i),
        .vl_i   (rd_vl_c),
        .step_i (rd_issue),
        .vreg_o (rd_vreg),
        .addr_o (rd_addr),
        .mask_o (rd_mask),
        .last_o (rd_last)
    );

    vrf_beat_gen u_wr_gen (
        .clk    (clk),
        .rst    (rst),
        .load_i (wr_fire),
        .vreg_i (wr_cmd_vreg_i),
        .vl_i   (wr_vl_c),
        .step_i (wr_beat),
        .vreg_o (wr_vreg),
        .addr_o (wr_addr),
        .mask_o (wr_mask),
        .last_o (wr_last)
    );

    always_comb begin
        rd_state_d = rd_state_q;
        rd_valid_d = rd_issue;
        rd_mask_d  = rd_issue ? rd_mask : '0;
        rd_last_d  = rd_issue && rd_last;
        case (rd_state_q)
            R_IDLE:  if (rd_fire && (rd_vl_c != '0)) rd_state_d = R_ISSUE;
            R_ISSUE: if (rd_last) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    // A zero-length write never enters W_DATA but still reports completion.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_done_d  = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (wr_fire) begin
                    if (wr_vl_c == '0) wr_done_d  = 1'b1;
                    else               wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wr_beat && wr_last) begin
                    wr_state_d = W_IDLE;
                    wr_done_d  = 1'b1;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            wr_state_q <= W_IDLE;
            rd_valid_q <= 1'b0;
            rd_mask_q  <= '0;
            rd_last_q  <= 1'b0;
            wr_done_q  <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            rd_valid_q <= rd_valid_d;
            rd_mask_q  <= rd_mask_d;
            rd_last_q  <= rd_last_d;
            wr_done_q  <= wr_done_d;
        end
    end

    assign rd_data_valid_o = rd_valid_q;
    assign rd_data_o       = sram_rdata_i;
    assign rd_data_mask_o  = rd_mask_q;
    assign rd_data_last_o  = rd_last_q;
    assign wr_data_ready_o = wr_active;
    assign wr_done_o       = wr_done_q;

    assign sram_re_o = rd_issue ? rd_mask : '0;
    assign sram_we_o = wr_beat  ? wr_mask : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NumBanks; gi++) begin : g_bank
            assign sram_r_addr_o[gi*AddrWidth +: AddrWidth] = rd_issue  ? rd_addr : '0;
            assign sram_w_addr_o[gi*AddrWidth +: AddrWidth] = wr_active ? wr_addr : '0;
            assign sram_wdata_o[gi*DataWidth +: DataWidth]  =
                wr_beat ? wr_data_i[gi*DataWidth +: DataWidth] : '0;
        end
    endgenerate

endmodule : vrf_access_seq
`default_nettype wire

// File: tb/tb_vrf_access_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_vrf_access_seq
// Brief  : Directed self-checking bench with a banked SRAM model and a
//          read-data scoreboard for vrf_access_seq.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_vrf_access_seq;

    localparam int NB = 4;
    localparam int DW = 32;
    localparam int AW = 8;

    typedef struct packed {
        logic [NB*DW-1:0] data;
        logic [NB-1:0]    mask;
        logic             last;
    } beat_s;

    logic              clk = 1'b0;
    logic              rst;
    logic              rd_cmd_valid, rd_cmd_ready;
    logic [4:0]        rd_cmd_vreg;
    logic [5:0]        rd_cmd_vl;
    logic              rd_data_valid, rd_data_last;
    logic [NB*DW-1:0]  rd_data;
    logic [NB-1:0]     rd_data_mask;
    logic              wr_cmd_valid, wr_cmd_ready;
    logic [4:0]        wr_cmd_vreg;
    logic [5:0]        wr_cmd_vl;
    logic              wr_data_valid, wr_data_ready;
    logic [NB*DW-1:0]  wr_data;
    logic              wr_done;
    logic [NB-1:0]     sram_re, sram_we;
    logic [NB*AW-1:0]  sram_r_addr, sram_w_addr;
    logic [NB*DW-1:0]  sram_wdata, sram_rdata;

    int                errors = 0;
    int                checks = 0;
    beat_s             exp_q[$];
    logic [DW-1:0]     ref_mem [1024];
    logic [DW-1:0]     mem [NB][256];
    logic [DW-1:0]     rdq [NB];
    logic              mem_init;

    always #5 clk = ~clk;

    vrf_access_seq dut (
        .clk             (clk),
        .rst             (rst),
        .rd_cmd_valid_i  (rd_cmd_valid),
        .rd_cmd_ready_o  (rd_cmd_ready),
        .rd_cmd_vreg_i   (rd_cmd_vreg),
        .rd_cmd_vl_i     (rd_cmd_vl),
        .rd_data_valid_o (rd_data_valid),
        .rd_data_o       (rd_data),
        .rd_data_mask_o  (rd_data_mask),
        .rd_data_last_o  (rd_data_last),
        .wr_cmd_valid_i  (wr_cmd_valid),
        .wr_cmd_ready_o  (wr_cmd_ready),
        .wr_cmd_vreg_i   (wr_cmd_vreg),
        .wr_cmd_vl_i     (wr_cmd_vl),
        .wr_data_valid_i (wr_data_valid),
        .wr_data_ready_o (wr_data_ready),
        .wr_data_i       (wr_data),
        .wr_done_o       (wr_done),
        .sram_re_o       (sram_re),
        .sram_we_o       (sram_we),
        .sram_r_addr_o   (sram_r_addr),
        .sram_w_addr_o   (sram_w_addr),
        .sram_wdata_o    (sram_wdata),
        .sram_rdata_i    (sram_rdata)
    );

    // Element g of the flat VRF lives in bank g%4 at address g/4.
    function automatic logic [DW-1:0] pat(input int g);
        return 32'hA500_0000 + 32'(g);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (mem_init) begin
                for (int a = 0; a < 256; a++) mem[i][a] <= pat(a * NB + i);
            end else begin
                if (sram_re[i]) rdq[i] <= mem[i][sram_r_addr[i*AW +: AW]];
                if (sram_we[i]) mem[i][sram_w_addr[i*AW +: AW]] <= sram_wdata[i*DW +: DW];
            end
        end
    end

    always_comb begin
        sram_rdata = '0;
        for (int i = 0; i < NB; i++) sram_rdata[i*DW +: DW] = rdq[i];
    end

    task automatic chk(input string tag, input logic [NB*DW-1:0] obs, input logic [NB*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NB-1:0] exp_mask(input int cvl, input int b);
        logic [NB-1:0] m;
        for (int i = 0; i < NB; i++) m[i] = (b * NB + i) < cvl;
        return m;
    endfunction

    function automatic logic [NB*AW-1:0] rep_addr(input int a);
        logic [NB*AW-1:0] r;
        for (int i = 0; i < NB; i++) r[i*AW +: AW] = AW'(a);
        return r;
    endfunction

    // Read-return scoreboard: only lanes enabled by the expected mask carry data.
    beat_s            mon_e;
    logic [NB*DW-1:0] mon_lm;
    always @(negedge clk) begin
        if (rd_data_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("rd_unexpected_beat", rd_data_valid, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                for (int i = 0; i < NB; i++) mon_lm[i*DW +: DW] = {DW{mon_e.mask[i]}};
                chk("rd_data", rd_data & mon_lm, mon_e.data & mon_lm);
                chk("rd_data_mask", rd_data_mask, mon_e.mask);
                chk("rd_data_last", rd_data_last, mon_e.last);
            end
        end
    end

    task automatic issue_check(input int v, input int cvl, input int b, input bit push);
        beat_s e;
        chk("sram_re", sram_re, exp_mask(cvl, b));
        chk("sram_r_addr", sram_r_addr, rep_addr(v * 8 + b));
        if (push) begin
            e.mask = exp_mask(cvl, b);
            e.last = (b == (cvl + 3) / 4 - 1);
            for (int i = 0; i < NB; i++) e.data[i*DW +: DW] = ref_mem[v * 32 + b * 4 + i];
            exp_q.push_back(e);
        end
    endtask

    // Tasks start and end 1 time unit after a rising edge.
    task automatic read_vr(input int v, input int vl, input int rst_at);
        int cvl, nb, cyc;
        cvl = (vl > 32) ? 32 : vl;
        nb  = (cvl + 3) / 4;
        rd_cmd_valid = 1'b1; rd_cmd_vreg = 5'(v); rd_cmd_vl = 6'(vl);
        cyc = 0;
        #1;
        while (!rd_cmd_ready && cyc < 60) begin @(posedge clk); #2; cyc++; end
        chk("rd_cmd_wait", cyc < 60, 1'b1);
        @(posedge clk); #1;
        rd_cmd_valid = 1'b0;
        if (nb == 0) begin
            for (int k = 0; k < 3; k++) begin
                #1;
                chk("rd_vl0_re", sram_re, '0);
                chk("rd_vl0_valid", rd_data_valid, 1'b0);
                @(posedge clk); #1;
            end
            return;
        end
        for (int b = 0; b < nb; b++) begin
            if (b == rst_at) rst = 1'b1;
            #1;
            chk("rd_data_valid_pipe", rd_data_valid, b > 0);
            chk("rd_cmd_ready_busy", rd_cmd_ready, 1'b0);
            issue_check(v, cvl, b, b != rst_at);
            @(posedge clk); #1;
            if (b == rst_at) begin
                rst = 1'b0;
                #1;
                chk("rst_rd_valid", rd_data_valid, 1'b0);
                chk("rst_rd_ready", rd_cmd_ready, 1'b1);
                chk("rst_wr_ready", wr_cmd_ready, 1'b1);
                chk("rst_q_empty", exp_q.size(), 0);
                @(posedge clk); #1;
                return;
            end
        end
        #1;
        chk("rd_last_valid", rd_data_valid & rd_data_last, 1'b1);
        chk("rd_ready_back", rd_cmd_ready, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic wr_cmd(input int v, input int vl);
        int cyc;
        wr_cmd_valid = 1'b1; wr_cmd_vreg = 5'(v); wr_cmd_vl = 6'(vl);
        cyc = 0;
        #1;
        while (!wr_cmd_ready && cyc < 60) begin @(posedge clk); #2; cyc++; end
        chk("wr_cmd_wait", cyc < 60, 1'b1);
        @(posedge clk); #1;
        wr_cmd_valid = 1'b0;
    endtask

    task automatic wr_beats(input int v, input int vl, input int seed);
        int cvl, nb;
        logic [NB-1:0] m;
        cvl = (vl > 32) ? 32 : vl;
        nb  = (cvl + 3) / 4;
        if (nb == 0) begin
            #1;
            chk("wr_vl0_done", wr_done, 1'b1);
            chk("wr_vl0_ready", wr_data_ready, 1'b0);
            @(posedge clk); #1;
            return;
        end
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < NB; i++) wr_data[i*DW +: DW] = 32'(seed + b * 4 + i);
            wr_data_valid = 1'b1;
            #1;
            m = exp_mask(cvl, b);
            chk("wr_data_ready", wr_data_ready, 1'b1);
            chk("sram_we", sram_we, m);
            chk("sram_w_addr", sram_w_addr, rep_addr(v * 8 + b));
            chk("sram_wdata", sram_wdata, wr_data);
            chk("wr_done_early", wr_done, 1'b0);
            chk("rd_ready_vs_wr", rd_cmd_ready, rd_cmd_vreg != 5'(v));
            for (int i = 0; i < NB; i++)
                if (m[i]) ref_mem[v * 32 + b * 4 + i] = wr_data[i*DW +: DW];
            @(posedge clk); #1;
        end
        wr_data_valid = 1'b0;
        #1;
        chk("wr_done", wr_done, 1'b1);
        chk("wr_ready_drop", wr_data_ready, 1'b0);
        chk("rd_ready_after_done", rd_cmd_ready, 1'b1);
        @(posedge clk); #1;
        chk("wr_done_pulse", wr_done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mem_init = 1'b1;
        rd_cmd_valid = 1'b0; rd_cmd_vreg = '0; rd_cmd_vl = '0;
        wr_cmd_valid = 1'b0; wr_cmd_vreg = '0; wr_cmd_vl = '0;
        wr_data_valid = 1'b0; wr_data = '0;
        for (int g = 0; g < 1024; g++) ref_mem[g] = pat(g);
        repeat (2) @(posedge clk);
        #1; mem_init = 1'b0;
        #1;
        chk("rst_rd_data_valid", rd_data_valid, 1'b0);
        chk("rst_rd_data_mask", rd_data_mask, '0);
        chk("rst_rd_data_last", rd_data_last, 1'b0);
        chk("rst_wr_done", wr_done, 1'b0);
        chk("rst_sram_re_we", {sram_re, sram_we}, '0);
        chk("rst_sram_addr", {sram_r_addr, sram_w_addr}, '0);
        chk("rst_sram_wdata", sram_wdata, '0);
        chk("rst_wr_data_ready", wr_data_ready, 1'b0);
        chk("rst_cmd_ready", {rd_cmd_ready, wr_cmd_ready}, 2'b11);
        @(posedge clk); #1;
        rst = 1'b0;

        // Full-length write then read back of v3.
        wr_cmd(3, 32);
        wr_beats(3, 32, 0);
        read_vr(3, 32, -1);

        // Tail handling on v5 with vl=6.
        read_vr(5, 6, -1);
        wr_cmd(5, 6);
        wr_beats(5, 6, 32'h500);
        read_vr(5, 8, -1);

        // Read of v7 blocked while its write waits for data; v8 is not.
        wr_cmd(7, 32);
        rd_cmd_vreg = 5'd7; #1;
        chk("haz_rd_v7_blocked", rd_cmd_ready, 1'b0);
        rd_cmd_vreg = 5'd8; #1;
        chk("haz_rd_v8_free", rd_cmd_ready, 1'b1);
        @(posedge clk); #1;
        rd_cmd_vreg = 5'd7; #1;
        chk("haz_rd_v7_still", rd_cmd_ready, 1'b0);
        @(posedge clk); #1;
        wr_beats(7, 32, 32'h700);
        read_vr(7, 32, -1);

        // Same-cycle read and write commands to v2: read wins.
        rd_cmd_valid = 1'b1; rd_cmd_vreg = 5'd2; rd_cmd_vl = 6'd8;
        wr_cmd_valid = 1'b1; wr_cmd_vreg = 5'd2; wr_cmd_vl = 6'd8;
        #1;
        chk("tie_rd_ready", rd_cmd_ready, 1'b1);
        chk("tie_wr_ready", wr_cmd_ready, 1'b0);
        @(posedge clk); #1;
        rd_cmd_valid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            #1;
            chk("tie_wr_blocked", wr_cmd_ready, 1'b0);
            issue_check(2, 8, b, 1'b1);
            @(posedge clk); #1;
        end
        #1;
        chk("tie_wr_released", wr_cmd_ready, 1'b1);
        @(posedge clk); #1;
        wr_cmd_valid = 1'b0;
        wr_beats(2, 8, 32'h200);
        read_vr(2, 8, -1);

        // Zero-length and over-length commands.
        read_vr(4, 0, -1);
        wr_cmd(6, 0);
        wr_beats(6, 0, 0);
        read_vr(9, 40, -1);

        // Reset during the third read beat, then normal operation resumes.
        read_vr(3, 32, 2);
        read_vr(3, 32, -1);

        repeat (2) @(posedge clk);
        #1;
        chk("end_q_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_vrf_access_seq
`default_nettype wire

// File: doc/vrf_access_seq.md
# vrf_access_seq

Sequencer that sits in front of the banked vector register file SRAM (`tc_sram`) and turns whole-vector-register read and write commands into per-beat, per-bank SRAM accesses. One beat covers NumBanks consecutive elements, and element e of register v lives in bank e % NumBanks. The block runs one read stream and one write stream concurrently, masks tail elements beyond vl, and blocks read/write commands that target the same vector register. Its consumers are the tensor-core operand fetch (read side) and the result writeback (write side).

## Interface
- NumWords, 1024: total elements in the VRF.
- NumBanks, 4: SRAM banks; must be a power of two.
- NumVRs, 32: vector registers.
- DataWidth, 32: element width.
- ElemsPerVR, NumWords/NumVRs (32): derived.
- BeatsPerVR, ElemsPerVR/NumBanks (8): derived.
- AddrWidth, $clog2(NumWords/NumBanks) (8): derived.
- VregW, $clog2(NumVRs); VlW, $clog2(ElemsPerVR+1): derived.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- rd_cmd_valid / rd_cmd_ready  in / out  1  read command handshake.
- rd_cmd_vreg  in  VregW  source register; rd_cmd_vl  in  VlW  element count.
- rd_data_valid  out  1; rd_data  out  NumBanks×DataWidth; rd_data_mask  out  NumBanks; rd_data_last  out  1.
- wr_cmd_valid / wr_cmd_ready  in / out  1; wr_cmd_vreg  in  VregW; wr_cmd_vl  in  VlW.
- wr_data_valid / wr_data_ready  in / out  1; wr_data  in  NumBanks×DataWidth.
- wr_done  out  1  one-cycle pulse when a write command completes.
- sram_re, sram_we  out  NumBanks  per-bank enables.
- sram_r_addr, sram_w_addr  out  NumBanks×AddrWidth; sram_wdata  out  NumBanks×DataWidth.
- sram_rdata  in  NumBanks×DataWidth  registered SRAM read data, valid one cycle after sram_re.

## Operation
- Address map: base = vreg×BeatsPerVR. Beat b drives address base+b on every bank. Bank i in beat b is active iff b×NumBanks+i < vl.
- Any vl > ElemsPerVR is clamped to ElemsPerVR. Beats issued = ceil(vl/NumBanks).
- Read FSM, R_IDLE→R_ISSUE:
  - A command is accepted on valid&ready, capturing vreg, clamped vl and beat counter 0.
  - R_ISSUE issues one beat per cycle with no stall: sram_re = mask, sram_r_addr = base+b.
  - After the last beat the FSM returns to R_IDLE.
  - A vl=0 command is accepted and produces no beats and no data.
- Read return: a 1-stage shadow register carries mask and last. The cycle after each issue, rd_data_valid=1, rd_data=sram_rdata, and mask/last come from the shadow. There is no backpressure on read data.
- Write FSM, W_IDLE→W_DATA:
  - In W_DATA, wr_data_ready=1. Each wr_data_valid cycle drives sram_we = mask, sram_w_addr = base+b, sram_wdata = wr_data, then increments b.
  - The last beat returns the FSM to W_IDLE and pulses wr_done on the next cycle.
  - A vl=0 write is accepted, enters no W_DATA state, and pulses wr_done on the next cycle.
- rd_cmd_ready = R_IDLE && !(W_DATA && wr vreg == rd_cmd_vreg).
- wr_cmd_ready = W_IDLE && !(R_ISSUE && rd vreg == wr_cmd_vreg) && !(rd_cmd_valid && rd_cmd_ready && rd_cmd_vreg == wr_cmd_vreg). When both commands arrive in the same cycle for the same register, the read wins.
- Reads and writes to different registers proceed in the same cycle. A bank may see re and we together.
- Reset:
  - Both FSMs go idle and counters clear.
  - rd_data_valid, rd_data_mask, rd_data_last, wr_done, sram_re and sram_we go to 0. Addresses and wdata also reset to 0.
  - Reset mid-operation drops the command; an in-flight read return is suppressed.

## Timing
- Read command accepted in cycle T: beats are issued in T+1..T+N and data appears in T+2..T+N+1. The next rd_cmd_ready comes at T+N+1.
- Write command accepted in cycle T: wr_data_ready is high from T+1. SRAM writes happen in the same cycle as each accepted data beat, and wr_done is high the cycle after the last beat.
- The SRAM-side outputs are combinational from FSM registers and wr_data. Everything else is registered.

## Structure
- Package `vrf_pkg` holds:
  - NumWords, NumBanks, NumVRs, DataWidth and the derived constants;
  - the vreg_t, vl_t, beat_t, bank_addr_t and bank_mask_t typedefs;
  - function `beat_mask(vl, beat)`.
- Sub-module `vrf_beat_gen` is instantiated twice, once per channel. It contains the beat counter, base/address generation, tail mask and the last flag.

## Test plan
- Write v3, vl=32, beat k holds {4k+3,4k+2,4k+1,4k}: expect 8 beats, sram_w_addr 24..31, sram_we=1111, wr_done the cycle after beat 8. Then read v3: 8 data beats with the same values, rd_data_last on the 8th, first data 2 cycles after accept.
- Read v5, vl=6: 2 beats at addresses 40 and 41, masks 1111 then 0011, last on beat 2. Write v5, vl=6: masks 1111 then 0011.
- Hazard: write v7 in progress with wr_data_valid held low; rd_cmd v7 gets ready=0 until wr_done. rd_cmd v8 in the same cycle is accepted immediately.
- Simultaneous read and write commands to v2 while both idle: read accepted, wr_cmd_ready=0 until the read FSM returns to idle.
- vl=0 read gives no rd_data_valid; vl=0 write gives wr_done the next cycle. A vl=40 command is clamped to 8 beats.
- Assert rst during read beat 3: rd_data_valid=0 from the next cycle and both cmd_ready=1 after reset releases.
